uart_word_tx: RTL
=================

UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 The block SHALL have parameter WORD_LENGTH, default 32, the width of the word to transmit; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 434, the number of clk cycles per UART bit (50 MHz / 115200); the minimum legal value SHALL be 2.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port SerialOutEn, input, 1, the transmit request; a rising edge starts a word.
REQ-006 The block SHALL have port SerialData, input, WORD_LENGTH, the word to send, sampled on the accepted request.
REQ-007 The block SHALL have port tx, output, 1, the UART serial line (8N1, idle high).
REQ-008 The block SHALL have port busy, output, 1, which is high from acceptance until TX_flag.
REQ-009 The block SHALL have port TX_flag, output, 1, a one-cycle pulse when the whole word has been sent.

Function
REQ-010 The block SHALL register SerialOutEn each cycle, and a request SHALL be a cycle with SerialOutEn=1 and registered previous value=0.
REQ-011 A request in state IDLE SHALL latch SerialData into a shift register, set busy=1 and enter START on the next edge.
REQ-012 A request while busy=1 SHALL be ignored with no effect on the word in flight; a level held high across DONE SHALL NOT retrigger.
REQ-013 The FSM states SHALL be IDLE, START, DATA, STOP and DONE.
REQ-014 The FSM transitions SHALL be: IDLE->START on request; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8 bit periods; STOP->START if bytes remain, else STOP->DONE, after CLKS_PER_BIT cycles; DONE->IDLE unconditionally after 1 cycle.
REQ-015 The tx output SHALL be 1 in IDLE and DONE, 0 in START, the current data bit in DATA, and 1 in STOP; tx SHALL be driven from a register (glitch-free).
REQ-016 Byte order SHALL be least-significant byte first, SerialData[7:0] first; bit order within a byte SHALL be LSB first.
REQ-017 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter that counts 0..CLKS_PER_BIT-1, wraps to 0 and advances the bit.
REQ-018 A 3-bit bit index SHALL count 0..7 in DATA, and a byte index SHALL count 0..WORD_LENGTH/8-1; both SHALL clear on acceptance.
REQ-019 The tx line SHALL fall on the first edge after the request cycle.
REQ-020 The total time from the first start bit to the end of the last stop bit SHALL be exactly (WORD_LENGTH/8)*10*CLKS_PER_BIT cycles.
REQ-021 TX_flag SHALL be 1 only in DONE, for exactly one cycle; busy SHALL fall on the same edge that enters IDLE.
REQ-022 A request in the cycle immediately following DONE (the first IDLE cycle) SHALL be accepted normally.
REQ-023 Changes on SerialData after acceptance SHALL NOT affect the transmitted bits.

Reset
REQ-024 When reset=0, asynchronously: state=IDLE, tx=1, busy=0, TX_flag=0, counters=0, shift register=0, and the registered SerialOutEn=0.
REQ-025 Reset asserted mid-word SHALL abort the word immediately, with tx=1 and no TX_flag pulse; after release the block SHALL wait in IDLE for a new rising edge.
REQ-026 If SerialOutEn is already high when reset releases, that SHALL count as a request on the first cycle after release.

Verification (CLKS_PER_BIT=4, WORD_LENGTH=32)
REQ-027 Test 1: SerialData=0xA5C30F81 with a single SerialOutEn pulse -> tx frames 0x81,0x0F,0xC3,0xA5; the first frame bits are 0,1,0,0,0,0,0,0,1,1, each 4 cycles; TX_flag is high exactly 160 cycles after tx first falls.
REQ-028 Test 2: SerialOutEn held high for 200 cycles -> exactly one word is sent and one TX_flag pulse occurs, with no retrigger.
REQ-029 Test 3: a second SerialOutEn edge with 0xFFFFFFFF at cycle 50 of the word -> it is ignored; the original bytes finish unchanged.
REQ-030 Test 4: reset=0 at cycle 70 of the word -> tx=1 and busy=0 immediately, and no TX_flag pulse occurs; a new request afterwards sends the full word correctly.
REQ-031 Test 5: a request in the first IDLE cycle after TX_flag with 0x00000000 -> accepted; four frames are sent with data bits all 0, and stop bits are 1.
REQ-032 Test 6: SerialData changed every cycle after acceptance -> the transmitted bits equal the value latched at acceptance.

Source files
------------

// File: rtl/uart_word_tx.sv
// UART word transmitter: sends a WORD_LENGTH-bit word as WORD_LENGTH/8 back-to-back
// 8N1 frames, least-significant byte first, then pulses TX_flag for one cycle.
module uart_word_tx #(
    parameter int WORD_LENGTH  = 32,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   SerialOutEn,
    input  logic [WORD_LENGTH-1:0] SerialData,
    output logic                   tx,
    output logic                   busy,
    output logic                   TX_flag
);

    localparam int NUM_BYTES = WORD_LENGTH / 8;
    localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int BAUD_W    = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t                 state_q;
    logic                   en_q;
    logic [WORD_LENGTH-1:0] shift_q;
    logic [BAUD_W-1:0]      baud_cnt_q;
    logic [2:0]             bit_idx_q;
    logic [BYTE_W-1:0]      byte_idx_q;
    logic                   tx_q;
    logic                   busy_q;
    logic                   flag_q;

    logic request;
    logic baud_wrap;

    assign request   = SerialOutEn & ~en_q;
    assign baud_wrap = (baud_cnt_q == BAUD_LAST);

    // The shift register always holds the current byte in [7:0]; one right shift per
    // data bit, so after eight shifts the next byte is already in place.
    // NOTE: every register here uses <= so all updates see the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            shift_q    <= '0;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            en_q <= SerialOutEn;
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    flag_q <= 1'b0;
                    if (request) begin
                        shift_q    <= SerialData;
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        byte_idx_q <= '0;
                        busy_q     <= 1'b1;
                        tx_q       <= 1'b0;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        baud_cnt_q <= '0;
                        tx_q       <= shift_q[0];
                        state_q    <= DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        baud_cnt_q <= '0;
                        shift_q    <= shift_q >> 1;
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q <= '0;
                            tx_q      <= 1'b1;
                            state_q   <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_wrap) begin
                        baud_cnt_q <= '0;
                        if (byte_idx_q == BYTE_LAST) begin
                            tx_q    <= 1'b1;
                            flag_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                            tx_q       <= 1'b0;
                            state_q    <= START;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    flag_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    flag_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign TX_flag = flag_q;

endmodule
